pic_rx: RTL and testbench
=========================

# pic_rx

Asynchronous serial (UART, 8 data bits, LSB first, 1 stop bit) receiver on `clock_system`; the receive-side counterpart of `pic_tx`. It recovers bytes from the serial PIC command line and presents each one as a byte plus a one-cycle strobe, so the strobe can drive the write enable of the PIC command FIFO (`pic_data` / `pic_ready` in `PIC`). Noise is filtered by a 2-flop synchronizer and 3-sample majority voting at mid-bit.

## Interface
- `CLKS_PER_BIT`, default 208: `clock_system` cycles per bit (24 MHz / 115200 baud); legal range 8..65535.
- `clock_system`  input  1  system clock (24 MHz).
- `rstn`  input  1  reset, asynchronous, active-low.
- `rx`  input  1  serial line, idles high, asynchronous to `clock_system`.
- `recv_data`  output  8  last good byte received; held until the next good byte.
- `recv_finish`  output  1  one-cycle pulse; `recv_data` is valid in the same cycle.
- `frame_err`  output  1  one-cycle pulse on bad stop bit (or bad parity when enabled).
- `busy`  output  1  high while the FSM is not in IDLE.

## Operation
- `rx` passes through 2 flops (reset value 1) to give `rx_s`. All FSM logic uses `rx_s`.
- H = CLKS_PER_BIT/2 (integer division). The bit counter `cnt` is wide enough to hold CLKS_PER_BIT-1.
- IDLE: `cnt`=0. When `rx_s`=0, go to START. Call this cycle t0.
- START: takes samples at cnt=H-1, H and H+1, and decides at cnt=H+1 by majority. If the vote is 1 (false start), return to IDLE with no pulse. If the vote is 0, clear `cnt` and go to DATA.
- DATA: each later decision is made when cnt=CLKS_PER_BIT-1. The 3 samples for it are taken at cnt=CLKS_PER_BIT-3, -2 and -1. On each decision the voted bit shifts into the MSB of the shift register (LSB first), and `cnt` is cleared. After 8 bits, go to STOP (or PARITY when enabled).
- STOP: decides the same way. Vote 1: load `recv_data` from the shift register, pulse `recv_finish`, go straight to IDLE. No wait for the end of the stop bit, so back-to-back frames are accepted.
- STOP vote 0: pulse `frame_err`, leave `recv_data` unchanged, go to BREAK.
- BREAK: stays until `rx_s`=1, then returns to IDLE. This stops a held-low line from producing a stream of frames.
- `recv_finish` and `frame_err` are never high in the same cycle.
- Reset (async, any state, including mid-frame): FSM→IDLE, `cnt`=0, shift register=0, sync flops=1. The partial frame is discarded with no pulse.

## Timing
- Reset values: `recv_data`=8'h00, `recv_finish`=0, `frame_err`=0, `busy`=0.
- `rx` falling edge → `rx_s` low: 2 cycles.
- Decision k (k=0 start, 1..8 data, 9 stop) happens at cycle t0+H+1+k·CLKS_PER_BIT.
- Without parity, `recv_finish` and `frame_err` rise at t0+H+2+9·CLKS_PER_BIT, one cycle after the stop decision (registered outputs).
- `busy` rises at t0+1 and falls in the same cycle as the strobe.
- A new start edge is accepted from the first cycle after the return to IDLE.
- The receiver tolerates ±3% baud mismatch against CLKS_PER_BIT.

## Configuration
- `PIC_RX_PARITY_EN` defined:
  - An even-parity bit is expected between data bit 7 and the stop bit, in an added PARITY state decided like a data bit.
  - A parity mismatch with a good stop bit: `frame_err` pulse, `recv_data` not updated, return to IDLE (not BREAK).
  - Strobe timing moves by +CLKS_PER_BIT: t0+H+2+10·CLKS_PER_BIT.
- Not defined: 8N1 only; no PARITY state exists.

## Test plan
- CLKS_PER_BIT=16, send 8'hA5 8N1 → one `recv_finish` with `recv_data`=8'hA5 at t0+H+2+9·16 = t0+154; `frame_err` stays 0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap → three `recv_finish` pulses carrying those values in order.
- Start pulse low for only 4 cycles → no pulse; `busy` falls at t0+H+2; `recv_data` unchanged.
- 8'h3C with stop bit low, line then held low 50 cycles → one `frame_err` pulse; `recv_data` keeps its old value; no further frame until the line goes high.
- Single 1-cycle glitch inside data bit 3 at its mid-sample → majority vote rejects it; correct byte received.
- `rstn` low during data bit 4, then 8'h81 → outputs reset; no pulse for the aborted frame; 8'h81 received correctly.
- With `PIC_RX_PARITY_EN`:
  - 8'h07 with parity bit 1 → `recv_finish` with 8'h07.
  - 8'h07 with parity bit 0 → `frame_err`.

Source files
------------

// File: rtl/pic_rx.sv
// ---------------------------------------------------------------------------
// pic_rx -- UART receiver (8 data bits, LSB first, 1 stop bit) for the serial
// PIC command line. This is the receive-side counterpart of pic_tx.
//
// The line goes through a 2-flop synchronizer. Each bit is then decided by a
// 3-sample majority vote taken around the bit centre. Every good byte appears
// on recv_data together with a one-cycle recv_finish strobe. That strobe can
// drive the write enable of the PIC command FIFO directly.
//
// Ports:
//   clock_system  in   system clock (24 MHz)
//   rstn          in   asynchronous active-low reset
//   rx            in   serial line, idles high, asynchronous to the clock
//   recv_data     out  [7:0] last good byte, held until the next good byte
//   recv_finish   out  one-cycle pulse, recv_data valid in the same cycle
//   frame_err     out  one-cycle pulse on bad stop bit (or bad parity)
//   busy          out  high while the receiver is not idle
//
// Parameter:
//   CLKS_PER_BIT  clock cycles per bit, legal range 8..65535
//
// Build option:
//   PIC_RX_PARITY_EN  when defined, an even-parity bit is expected between
//                     data bit 7 and the stop bit (8E1). When not defined,
//                     the receiver handles 8N1 only.
// ---------------------------------------------------------------------------
module pic_rx #(
    parameter int CLKS_PER_BIT = 208
) (
    input  logic       clock_system,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] recv_data,
    output logic       recv_finish,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // The start bit is decided at its centre. Later bits are decided one
    // full bit period after the previous decision.
    localparam logic [CW-1:0] START_DEC = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] BIT_DEC   = CW'(CLKS_PER_BIT - 1);

`ifdef PIC_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [1:0]      hist_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      recv_data_q;
    logic            finish_q;
    logic            err_q;
    logic            busy_q;
`ifdef PIC_RX_PARITY_EN
    logic            par_q;
    logic            par_ok;
`endif

    logic            rx_s;
    logic            vote;

    assign rx_s = sync_q[1];

    // hist_q holds rx_s from the two previous cycles. The vote at a decision
    // cycle therefore covers cnt-2, cnt-1 and cnt.
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

`ifdef PIC_RX_PARITY_EN
    // Even parity: data ones plus the parity bit must give an even count.
    assign par_ok = ((^shift_q) == par_q);
`endif

    always_ff @(posedge clock_system or negedge rstn) begin
        if (!rstn) begin
            sync_q      <= 2'b11;
            hist_q      <= 2'b11;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            recv_data_q <= '0;
            finish_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PIC_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync_q   <= {sync_q[0], rx};
            hist_q   <= {hist_q[0], rx_s};
            finish_q <= 1'b0;
            err_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        // The cycle that sees the edge counts as cnt=0.
                        state_q <= S_START;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == START_DEC) begin
                        cnt_q <= '0;
                        if (vote) begin
                            // A glitch, not a start bit.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q   <= '0;
                        shift_q <= {vote, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef PIC_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

`ifdef PIC_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q   <= '0;
                        par_q   <= vote;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == BIT_DEC) begin
                        cnt_q <= '0;
                        if (!vote) begin
                            // Bad stop bit. Wait in BREAK so that a held-low
                            // line cannot produce a stream of frames.
                            err_q   <= 1'b1;
                            state_q <= S_BREAK;
`ifdef PIC_RX_PARITY_EN
                        end else if (!par_ok) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            // Return at mid stop bit so a back-to-back start
                            // edge is not missed.
                            recv_data_q <= shift_q;
                            finish_q    <= 1'b1;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign recv_data   = recv_data_q;
    assign recv_finish = finish_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pic_rx.sv
module tb_pic_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] recv_data;
    logic       recv_finish;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    pic_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock_system (clk),
        .rstn         (rstn),
        .rx           (rx),
        .recv_data    (recv_data),
        .recv_finish  (recv_finish),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // cyc equals the number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Scoreboard entries are {is_frame_err, expected recv_data}.
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    logic [7:0] last_good = 8'h00;
    int         last_evt_cyc = -1;
    int         n_evt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: each strobe pops one expected event and compares it.
    always @(negedge clk) begin
        if (recv_finish || frame_err) begin
            n_evt++;
            last_evt_cyc = cyc;
            check("strobes_exclusive", {31'b0, recv_finish & frame_err}, 32'd0);
            check("event_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check("event_kind_err", {31'b0, frame_err}, {31'b0, exp_e[8]});
                check("event_data", {24'b0, recv_data}, {24'b0, exp_e[7:0]});
            end
        end
    end

    // Every drive starts 1 time unit after a rising edge.
    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        while (1) begin
            @(negedge clk);
            if (cyc >= n) break;
        end
    endtask

    // glitch_bit selects a data bit that gets a 1-cycle inversion at its
    // centre sample. Use -1 for no glitch.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_b, input int glitch_bit);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(d[i], H);
                drive(~d[i], 1);
                drive(d[i], CPB - H - 1);
            end else begin
                drive(d[i], CPB);
            end
        end
`ifdef PIC_RX_PARITY_EN
        drive(par_b, CPB);
`else
        if (par_b === 1'bx) drive(1'b1, 0);
`endif
        drive(stop_b, CPB);
    endtask

    task automatic push_good(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        last_good = d;
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, last_good});
    endtask

`ifdef PIC_RX_PARITY_EN
    localparam int STROBE_OFS = 2 + H + 2 + 10 * CPB;
`else
    localparam int STROBE_OFS = 2 + H + 2 + 9 * CPB;
`endif

    int c0;
    int evt0;

    initial begin
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_recv_data", {24'b0, recv_data}, 32'h00);
        check("rst_recv_finish", {31'b0, recv_finish}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(1'b1, 5);

        // Single 8'hA5 frame. rx_s falls 2 cycles after rx (that cycle is t0).
        // busy rises at t0+1 and the strobe comes at t0+H+2+9*CPB.
        c0   = cyc;
        evt0 = n_evt;
        push_good(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5, -1);
            begin
                at_cycle(c0 + 2);
                check("busy_before_t0p1", {31'b0, busy}, 32'd0);
                at_cycle(c0 + 3);
                check("busy_at_t0p1", {31'b0, busy}, 32'd1);
            end
        join
        drive(1'b1, 4);
        check("a5_strobe_cycle", last_evt_cyc, c0 + STROBE_OFS);
        check("a5_event_count", n_evt - evt0, 32'd1);
        check("a5_busy_idle", {31'b0, busy}, 32'd0);

        // Back-to-back frames with no idle gap.
        evt0 = n_evt;
        push_good(8'h00);
        push_good(8'hFF);
        push_good(8'h55);
        send_frame(8'h00, 1'b1, ^8'h00, -1);
        send_frame(8'hFF, 1'b1, ^8'hFF, -1);
        send_frame(8'h55, 1'b1, ^8'h55, -1);
        drive(1'b1, 6);
        check("b2b_event_count", n_evt - evt0, 32'd3);

        // False start: low for only 4 cycles. busy falls at t0+H+2.
        c0   = cyc;
        evt0 = n_evt;
        fork
            begin
                drive(1'b0, 4);
                rx = 1'b1;
            end
            begin
                at_cycle(c0 + 2 + H + 1);
                check("false_start_busy_hi", {31'b0, busy}, 32'd1);
                at_cycle(c0 + 2 + H + 2);
                check("false_start_busy_lo", {31'b0, busy}, 32'd0);
            end
        join
        drive(1'b1, 20);
        check("false_start_no_event", n_evt - evt0, 32'd0);
        check("false_start_data_held", {24'b0, recv_data}, 32'h55);

        // Bad stop bit, then the line is held low for 50 more cycles.
        evt0 = n_evt;
        push_err();
        send_frame(8'h3C, 1'b0, ^8'h3C, -1);
        drive(1'b0, 50);
        check("break_busy_held", {31'b0, busy}, 32'd1);
        check("break_one_event", n_evt - evt0, 32'd1);
        check("break_data_held", {24'b0, recv_data}, 32'h55);
        drive(1'b1, 5);
        check("break_exit_busy", {31'b0, busy}, 32'd0);

        // 1-cycle glitch at the centre sample of data bit 3.
        evt0 = n_evt;
        push_good(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A, 3);
        drive(1'b1, 4);
        check("glitch_event_count", n_evt - evt0, 32'd1);

        // Reset during data bit 4 of a frame, then receive 8'h81.
        evt0 = n_evt;
        drive(1'b0, CPB * 5 + H);
        check("abort_busy_before_rst", {31'b0, busy}, 32'd1);
        rstn = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        check("abort_rst_data", {24'b0, recv_data}, 32'h00);
        check("abort_rst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        last_good = 8'h00;
        drive(1'b1, 5);
        check("abort_no_event", n_evt - evt0, 32'd0);
        push_good(8'h81);
        send_frame(8'h81, 1'b1, ^8'h81, -1);
        drive(1'b1, 4);
        check("after_rst_event_count", n_evt - evt0, 32'd1);

`ifdef PIC_RX_PARITY_EN
        // Parity: good, then wrong parity with a good stop bit.
        evt0 = n_evt;
        push_good(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        push_err();
        send_frame(8'h07, 1'b1, 1'b0, -1);
        drive(1'b1, 4);
        check("parity_event_count", n_evt - evt0, 32'd2);
        check("parity_busy_idle", {31'b0, busy}, 32'd0);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
